// File: rtl/data_mem_arbiter.sv
// Arbitrates the single dataMemory port between the CPU load/store unit and host DMA.
// One request in flight; each requester gets a valid/ready request and a one-cycle response pulse.
module data_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_priority,

  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [1:0]        cpu_req_size,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,

  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_write,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [1:0]        dma_req_size,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_rdata,
  output logic              dma_rsp_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic [1:0]        mem_sizeSelect,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,

  output logic              grant_owner
);

  // state | meaning
  // IDLE  | waiting for a request, ready driven toward the winner
  // ISSUE | one-cycle memRead/memWrite strobe
  // WAIT  | counting down the memory read latency
  // RESP  | one-cycle response pulse to the owner
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t            state;
  logic              last_dma;
  logic              req_write;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              dma_wins;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;

  // CPU wins ties only when prioritised or when DMA was served last
  assign dma_wins      = dma_req_valid && (!cpu_req_valid || (!cpu_priority && !last_dma));
  assign cpu_req_ready = !rst && (state == IDLE) && cpu_req_valid && !dma_wins;
  assign dma_req_ready = !rst && (state == IDLE) && dma_wins;
  assign accept        = cpu_req_ready || dma_req_ready;

  assign sel_write = dma_wins ? dma_req_write : cpu_req_write;
  assign sel_addr  = dma_wins ? dma_req_addr  : cpu_req_addr;
  assign sel_size  = dma_wins ? dma_req_size  : cpu_req_size;
  assign sel_wdata = dma_wins ? dma_req_wdata : cpu_req_wdata;

  always_comb begin
    misaligned = 1'b0;
    case (sel_size)
      2'd1:    misaligned = sel_addr[0];
      2'd2:    misaligned = |sel_addr[1:0];
      2'd3:    misaligned = |sel_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign cpu_rsp_rdata = rsp_rdata;
  assign dma_rsp_rdata = rsp_rdata;
  assign cpu_rsp_err   = rsp_err;
  assign dma_rsp_err   = rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_dma       <= 1'b1;
      grant_owner    <= 1'b0;
      req_write      <= 1'b0;
      cnt            <= 3'd0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      cpu_rsp_valid  <= 1'b0;
      dma_rsp_valid  <= 1'b0;
      mem_address    <= '0;
      mem_memRead    <= 1'b0;
      mem_memWrite   <= 1'b0;
      mem_sizeSelect <= 2'd0;
      mem_writeData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_owner <= dma_wins;
            last_dma    <= dma_wins;
            req_write   <= sel_write;
            if (misaligned) begin
              rsp_rdata     <= '0;
              rsp_err       <= 1'b1;
              cpu_rsp_valid <= !dma_wins;
              dma_rsp_valid <= dma_wins;
              state         <= RESP;
            end else begin
              mem_address    <= sel_addr;
              mem_sizeSelect <= sel_size;
              mem_writeData  <= sel_wdata;
              mem_memRead    <= !sel_write;
              mem_memWrite   <= sel_write;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_memRead  <= 1'b0;
          mem_memWrite <= 1'b0;
          if (req_write) begin
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            cpu_rsp_valid <= !grant_owner;
            dma_rsp_valid <= grant_owner;
            state         <= RESP;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rsp_rdata     <= mem_readData;
            rsp_err       <= 1'b0;
            cpu_rsp_valid <= !grant_owner;
            dma_rsp_valid <= grant_owner;
            state         <= RESP;
          end
        end
        RESP: begin
          cpu_rsp_valid <= 1'b0;
          dma_rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
